// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types and constants for the instruction fetch / prefetch stage.
package fetch_prefetch_unit_pkg;

    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            misalign;
    } fetch_entry_t;

    // Counters must hold the value DEPTH itself, not just DEPTH-1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_sync_fifo.sv
// Single-clock FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty && !flush;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push && !flush && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage with prefetch queue and redirect flushing.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int              XLEN     = ILEN,
    parameter int              DEPTH    = DEFAULT_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            if_misalign
);
    localparam int               CNT_W   = cnt_width(DEPTH);
    localparam logic [CNT_W:0]   CREDITS = (CNT_W + 1)'(DEPTH);

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  redirect_target;
    logic [XLEN-1:0]  tag_head;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] tag_count;
    logic [CNT_W:0]   credit_used;
    logic             halted;
    logic             grant;
    logic             rsp_fire;
    logic             q_push;
    logic             q_pop;
    logic             marker_push;
    logic             q_full;
    logic             q_empty;
    logic             tag_full;
    logic             tag_empty;
    fetch_entry_t     q_push_data;
    fetch_entry_t     q_head;

    // Queued plus outstanding fetches never exceed DEPTH, so responses always fit.
    assign credit_used = {1'b0, q_count} + {1'b0, inflight};
    assign imem_req    = reset && !redirect_valid && !halted && (credit_used < CREDITS);
    assign imem_addr   = pc;
    assign grant       = imem_req && imem_gnt;
    assign rsp_fire    = imem_rvalid && (inflight != '0);

    assign q_push   = (rsp_fire && (drop_cnt == '0) && !redirect_valid) || marker_push;
    assign q_pop    = if_valid && if_ready && !redirect_valid;
    assign if_valid = (q_count != '0);
    assign if_pc    = q_head.pc;
    assign if_instr = q_head.instr;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            marker_pending;
    logic [XLEN-1:0] trap_pc;

    assign redirect_target = redirect_pc;
    // The marker waits until every stale response has drained and decode has emptied the queue.
    assign marker_push = marker_pending && (drop_cnt == '0) && q_empty && !redirect_valid;
    assign q_push_data = marker_push ? {trap_pc, NOP_INSTR, 1'b1}
                                     : {tag_head, imem_rdata, 1'b0};
    assign if_misalign = q_head.misalign;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted         <= 1'b0;
            marker_pending <= 1'b0;
            trap_pc        <= '0;
        end else if (redirect_valid) begin
            halted         <= (redirect_pc[1:0] != 2'b00);
            marker_pending <= (redirect_pc[1:0] != 2'b00);
            trap_pc        <= redirect_pc;
        end else if (marker_push) begin
            marker_pending <= 1'b0;
        end
    end
`else
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
    assign halted          = 1'b0;
    assign marker_push     = 1'b0;
    assign q_push_data     = {tag_head, imem_rdata, 1'b0};
    assign if_misalign     = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, q_full, q_empty, tag_full, tag_empty, tag_count,
                         redirect_pc[1:0], q_head.misalign};

    // Every response still outstanding at a redirect belongs to the old path and is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight + CNT_W'(grant) - CNT_W'(rsp_fire);
            if (redirect_valid) begin
                pc       <= redirect_target;
                drop_cnt <= inflight - CNT_W'(rsp_fire);
            end else begin
                if (grant) pc <= pc + XLEN'(4);
                if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .pop_data  (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Tags are never flushed: dropped responses still consume their tag.
    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tags (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (grant),
        .push_data (pc),
        .pop       (rsp_fire),
        .pop_data  (tag_head),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomised self-checking bench for fetch_prefetch_unit against a queue-level reference model.
module tb_fetch_prefetch_unit;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misalign;

    fetch_prefetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_instr(if_instr), .if_misalign(if_misalign)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] out_pc[$];
    bit          out_stale[$];
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    logic [31:0] model_pc;
    logic [31:0] trap_pc;
    bit          model_halt;
    bit          marker_pend;
    int          checks;
    int          errors;
    int          cyc;
    int          last_due;
    int          lat_min;
    int          lat_max;
    int          grants;
    int          pops;
    bit          seen_pop;
    logic [31:0] first_pop_pc;
    logic [31:0] last_pop_pc;
    bit          obs_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int stale_count();
        int n = 0;
        foreach (out_stale[i]) if (out_stale[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        out_pc.delete();
        out_stale.delete();
        mem_addr_q.delete();
        mem_due_q.delete();
        model_pc    = 32'h0;
        model_halt  = 1'b0;
        marker_pend = 1'b0;
        trap_pc     = 32'h0;
        last_due    = cyc;
    endtask

    // One clock cycle: drive at negedge, check settled outputs, advance the model past the posedge.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit gnt, input bit rdy);
        bit          exp_req, rsp, pop, grant, mark, st;
        logic [31:0] p;
        int          due;
        @(negedge clk);
        cyc++;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_gnt       = gnt;
        if_ready       = rdy;
        rsp            = (mem_due_q.size() != 0) && (mem_due_q[0] <= cyc);
        imem_rvalid    = rsp;
        imem_rdata     = rsp ? mem_word(mem_addr_q[0]) : $urandom;
        #1;
        obs_valid = if_valid;
        exp_req = !redir && !model_halt && ((exp_q.size() + out_pc.size()) < DEPTH);
        checks++;
        if (imem_req !== exp_req) begin
            errors++;
            $display("[TB] FAIL imem_req cyc=%0d: got %b expected %b", cyc, imem_req, exp_req);
        end
        if (exp_req) begin
            checks++;
            if (imem_addr !== model_pc) begin
                errors++;
                $display("[TB] FAIL imem_addr cyc=%0d: got %h expected %h", cyc, imem_addr, model_pc);
            end
        end
        checks++;
        if (if_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("[TB] FAIL if_valid cyc=%0d: got %b expected %b", cyc, if_valid, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
            checks += 3;
            if (if_pc !== exp_q[0].pc) begin
                errors++;
                $display("[TB] FAIL if_pc cyc=%0d: got %h expected %h", cyc, if_pc, exp_q[0].pc);
            end
            if (if_instr !== exp_q[0].instr) begin
                errors++;
                $display("[TB] FAIL if_instr cyc=%0d: got %h expected %h", cyc, if_instr, exp_q[0].instr);
            end
            if (if_misalign !== exp_q[0].mis) begin
                errors++;
                $display("[TB] FAIL if_misalign cyc=%0d: got %b expected %b", cyc, if_misalign, exp_q[0].mis);
            end
        end
        if (rsp) assert (out_pc.size() != 0);

        grant = imem_req && gnt;
        pop   = (exp_q.size() != 0) && rdy && !redir;
        mark  = marker_pend && (out_pc.size() == 0) && (exp_q.size() == 0) && !redir;
        if (pop) begin
            pops++;
            last_pop_pc = exp_q[0].pc;
            if (!seen_pop) begin
                seen_pop     = 1'b1;
                first_pop_pc = exp_q[0].pc;
            end
            void'(exp_q.pop_front());
        end
        if (redir) begin
            exp_q.delete();
            foreach (out_stale[i]) out_stale[i] = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
            model_pc    = rpc;
            model_halt  = (rpc[1:0] != 2'b00);
            marker_pend = model_halt;
            trap_pc     = rpc;
`else
            model_pc = {rpc[31:2], 2'b00};
`endif
        end
        if (rsp) begin
            p  = out_pc.pop_front();
            st = out_stale.pop_front();
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
            if (!st) exp_q.push_back({p, mem_word(p), 1'b0});
        end
        if (mark) begin
            exp_q.push_back({trap_pc, NOP, 1'b1});
            marker_pend = 1'b0;
        end
        if (grant) begin
            grants++;
            out_pc.push_back(model_pc);
            out_stale.push_back(1'b0);
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_addr_q.push_back(imem_addr);
            mem_due_q.push_back(due);
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        if_ready       = 1'b0;
        imem_rvalid    = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            #1;
            checks += 2;
            if (imem_req !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_req: got %b expected 0", imem_req);
            end
            if (if_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_valid: got %b expected 0", if_valid);
            end
            @(negedge clk);
            cyc++;
            imem_rvalid = ~imem_rvalid;
            imem_rdata  = $urandom;
        end
        imem_rvalid = 1'b0;
        reset       = 1'b1;
        last_due    = cyc;
        #1;
        checks += 2;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_req: got %b expected 1", imem_req);
        end
        if (imem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL release_addr: got %h expected 00000000", imem_addr);
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        apply_reset(3);
    endtask

    task automatic test_streaming();
        int first_valid = 0;
        $display("[TB] test_streaming");
        apply_reset(2);
        lat_min = 1; lat_max = 1; pops = 0;
        for (int i = 1; i <= 30; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (obs_valid && first_valid == 0) first_valid = i;
        end
        checks += 3;
        if (first_valid != 3) begin
            errors++;
            $display("[TB] FAIL stream_latency: got %0d expected 3", first_valid);
        end
        if (pops != 28) begin
            errors++;
            $display("[TB] FAIL stream_throughput: got %0d expected 28", pops);
        end
        if (last_pop_pc !== 32'h6C) begin
            errors++;
            $display("[TB] FAIL stream_last_pc: got %h expected 0000006c", last_pop_pc);
        end
    endtask

    task automatic test_backpressure();
        int g0;
        $display("[TB] test_backpressure");
        apply_reset(1);
        lat_min = 1; lat_max = 1;
        g0 = grants;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        checks += 2;
        if (grants - g0 != 4) begin
            errors++;
            $display("[TB] FAIL bp_grants: got %0d expected 4", grants - g0);
        end
        if (imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_req_held: got %b expected 0", imem_req);
        end
        pops = 0;
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (pops < 16) begin
            errors++;
            $display("[TB] FAIL bp_resume: got %0d pops expected at least 16", pops);
        end
    endtask

    task automatic test_redirect();
        $display("[TB] test_redirect");
        apply_reset(1);
        lat_min = 3; lat_max = 3;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h100, 1'b1, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (dut.drop_cnt !== 3'(stale_count())) begin
            errors++;
            $display("[TB] FAIL redirect_drop: got %0d expected %0d", dut.drop_cnt, stale_count());
        end
        seen_pop = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (!seen_pop || first_pop_pc !== 32'h100) begin
            errors++;
            $display("[TB] FAIL redirect_first_pc: got %h expected 00000100", first_pop_pc);
        end
    endtask

    task automatic test_simultaneous();
        bit found = 1'b0;
        $display("[TB] test_simultaneous");
        apply_reset(1);
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 50 && !found; i++) begin
            if (mem_due_q.size() != 0 && mem_due_q[0] <= cyc + 1 && exp_q.size() != 0 && i > 4)
                found = 1'b1;
            else
                step(1'b0, 32'h0, 1'b1, 1'b1);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL simul_setup: got no rvalid+pop cycle expected one within 50");
        end else begin
            step(1'b1, 32'h300, 1'b1, 1'b1);
            @(posedge clk); #1;
            checks += 2;
            if (if_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL simul_flush: got %b expected 0", if_valid);
            end
            if (dut.drop_cnt !== 3'(stale_count())) begin
                errors++;
                $display("[TB] FAIL simul_drop: got %0d expected %0d", dut.drop_cnt, stale_count());
            end
            seen_pop = 1'b0;
            for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
            checks++;
            if (!seen_pop || first_pop_pc !== 32'h300) begin
                errors++;
                $display("[TB] FAIL simul_first_pc: got %h expected 00000300", first_pop_pc);
            end
        end
    endtask

    task automatic test_back_to_back();
        $display("[TB] test_back_to_back");
        apply_reset(1);
        lat_min = 3; lat_max = 4;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h400, 1'b1, 1'b1);
        step(1'b1, 32'h500, 1'b1, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (dut.drop_cnt !== 3'(stale_count())) begin
            errors++;
            $display("[TB] FAIL b2b_drop: got %0d expected %0d", dut.drop_cnt, stale_count());
        end
        seen_pop = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (!seen_pop || first_pop_pc !== 32'h500) begin
            errors++;
            $display("[TB] FAIL b2b_first_pc: got %h expected 00000500", first_pop_pc);
        end
    endtask

    task automatic test_random();
        bit redir;
        $display("[TB] test_random");
        apply_reset(1);
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 800; i++) begin
            redir = ($urandom_range(15, 0) == 0);
            step(redir, $urandom & 32'h0000_0FFF, ($urandom_range(3, 0) != 0), $urandom_range(1, 0) == 1);
        end
    endtask

    task automatic test_reset_midstream();
        $display("[TB] test_reset_midstream");
        lat_min = 2; lat_max = 3;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        apply_reset(2);
        for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    endtask

`ifdef FETCH_MISALIGN_TRAP_EN
    task automatic test_misalign();
        int g0;
        $display("[TB] test_misalign");
        apply_reset(1);
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h102, 1'b1, 1'b0);
        g0 = grants;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks += 5;
        if (grants != g0) begin
            errors++;
            $display("[TB] FAIL mis_no_fetch: got %0d grants expected 0", grants - g0);
        end
        if (if_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mis_valid: got %b expected 1", if_valid);
        end
        if (if_pc !== 32'h102) begin
            errors++;
            $display("[TB] FAIL mis_pc: got %h expected 00000102", if_pc);
        end
        if (if_instr !== NOP) begin
            errors++;
            $display("[TB] FAIL mis_instr: got %h expected 00000013", if_instr);
        end
        if (if_misalign !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mis_flag: got %b expected 1", if_misalign);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        seen_pop = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (!seen_pop || first_pop_pc !== 32'h200) begin
            errors++;
            $display("[TB] FAIL mis_resume_pc: got %h expected 00000200", first_pop_pc);
        end
    endtask
`endif

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        if_ready       = 1'b0;
        checks = 0; errors = 0; cyc = 0; grants = 0; pops = 0;
        lat_min = 1; lat_max = 1; seen_pop = 1'b0;
        first_pop_pc = 32'h0; last_pop_pc = 32'h0; obs_valid = 1'b0;
        model_reset();
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_simultaneous();
        test_back_to_back();
        test_random();
        test_reset_midstream();
`ifdef FETCH_MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
